// File: rtl/load_extender.sv
// MEM-stage load-return unit: word read over a req/ack bus, byte/halfword select, zero/sign extension.
// Define LOAD_EXT_EXC_EN to enable the misaligned-address exception; otherwise addr_exc stays 0.
module load_extender #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ld_req,
  input  logic [2:0]  ld_op,
  input  logic [31:0] addr,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic [31:0] rd_data,
  output logic        rd_valid,
  output logic        bus_err,
  output logic        addr_exc,
  output logic        stall
);

`ifdef LOAD_EXT_EXC_EN
  localparam bit EXC_EN = 1'b1;
`else
  localparam bit EXC_EN = 1'b0;
`endif

  localparam logic [7:0] TIMEOUT_M1 = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        mem_req_q, mem_req_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] rd_data_q, rd_data_d;
  logic        rd_valid_q, rd_valid_d;
  logic        bus_err_q, bus_err_d;
  logic        addr_exc_q, addr_exc_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [2:0]  op_q, op_d;
  logic [1:0]  boff_q, boff_d;
  logic        stall_s;

  // Reserved op codes 101-111 behave as LW, including the alignment rule.
  function automatic logic is_misaligned(input logic [2:0] op, input logic [1:0] boff);
    case (op)
      3'b001, 3'b010: is_misaligned = 1'b0;
      3'b011, 3'b100: is_misaligned = boff[0];
      default:        is_misaligned = (boff != 2'b00);
    endcase
  endfunction

  // Halfword lane uses only boff[1], so low bits round down naturally when unchecked.
  function automatic logic [31:0] extend_load(input logic [2:0] op, input logic [1:0] boff,
                                              input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    case (boff)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = boff[1] ? word[31:16] : word[15:0];
    case (op)
      3'b001:  extend_load = {24'h000000, b};
      3'b010:  extend_load = {{24{b[7]}}, b};
      3'b011:  extend_load = {16'h0000, h};
      3'b100:  extend_load = {{16{h[15]}}, h};
      default: extend_load = word;
    endcase
  endfunction

  always_comb begin
    state_d    = state_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    bus_err_d  = 1'b0;
    addr_exc_d = 1'b0;
    cnt_d      = cnt_q;
    op_d       = op_q;
    boff_d     = boff_q;
    stall_s    = 1'b0;
    case (state_q)
      IDLE: begin
        stall_s = ld_req;
        if (ld_req) begin
          op_d       = ld_op;
          boff_d     = addr[1:0];
          mem_addr_d = {addr[31:2], 2'b00};
          if (EXC_EN && is_misaligned(ld_op, addr[1:0])) begin
            state_d    = DONE;
            rd_valid_d = 1'b1;
            addr_exc_d = 1'b1;
            rd_data_d  = 32'h0000_0000;
          end else begin
            state_d   = WAIT;
            mem_req_d = 1'b1;
            cnt_d     = 8'd0;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        stall_s = 1'b1;
        if (mem_ack) begin
          rd_data_d  = extend_load(op_q, boff_q, mem_rdata);
          rd_valid_d = 1'b1;
          mem_req_d  = 1'b0;
          state_d    = DONE;
        end else if (cnt_q == TIMEOUT_M1) begin
          rd_data_d  = 32'h0000_0000;
          rd_valid_d = 1'b1;
          bus_err_d  = 1'b1;
          mem_req_d  = 1'b0;
          state_d    = DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DONE: begin
        // ld_req here still names the finished load, so it is not looked at.
        state_d   = IDLE;
        rd_data_d = 32'h0000_0000;
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      mem_req_q  <= 1'b0;
      mem_addr_q <= 32'h0000_0000;
      rd_data_q  <= 32'h0000_0000;
      rd_valid_q <= 1'b0;
      bus_err_q  <= 1'b0;
      addr_exc_q <= 1'b0;
      cnt_q      <= 8'd0;
      op_q       <= 3'b000;
      boff_q     <= 2'b00;
    end else begin
      state_q    <= state_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      bus_err_q  <= bus_err_d;
      addr_exc_q <= addr_exc_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      boff_q     <= boff_d;
    end
  end

  assign mem_req  = mem_req_q;
  assign mem_addr = mem_addr_q;
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign bus_err  = bus_err_q;
  assign addr_exc = addr_exc_q;
  assign stall    = reset ? 1'b0 : stall_s;

endmodule

// File: tb/tb_load_extender.sv
// Randomized self-checking bench for load_extender against a transaction-level reference model.
module tb_load_extender;
  localparam int TIMEOUT = 16;
`ifdef LOAD_EXT_EXC_EN
  localparam bit EXC = 1'b1;
`else
  localparam bit EXC = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, ld_req, mem_req, mem_ack, rd_valid, bus_err, addr_exc, stall;
  logic [2:0]  ld_op;
  logic [31:0] addr, mem_addr, mem_rdata, rd_data;
  int          n_checks = 0;
  int          n_errors = 0;

  load_extender #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .ld_req(ld_req), .ld_op(ld_op), .addr(addr),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .rd_data(rd_data), .rd_valid(rd_valid), .bus_err(bus_err), .addr_exc(addr_exc),
    .stall(stall)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_load(input int op, input logic [31:0] a, input logic [31:0] w);
    logic [31:0] bv, hv;
    bv = (w >> (8 * a[1:0])) & 32'h0000_00FF;
    hv = (w >> (16 * a[1])) & 32'h0000_FFFF;
    case (op)
      1: return bv;
      2: return (bv >= 32'h80) ? bv - 32'h100 : bv;
      3: return hv;
      4: return (hv >= 32'h8000) ? hv - 32'h1_0000 : hv;
      default: return w;
    endcase
  endfunction

  function automatic bit ref_misaligned(input int op, input logic [31:0] a);
    if (op == 1 || op == 2) return 1'b0;
    if (op == 3 || op == 4) return (a % 2) != 0;
    return (a % 4) != 0;
  endfunction

  // One load from its IDLE cycle through its rd_valid cycle; dly<0 means no ack ever.
  task automatic do_load(input int op, input logic [31:0] a, input logic [31:0] w, input int dly);
    bit          mis, berr;
    int          done_cyc;
    logic [31:0] exp;
    mis  = EXC && ref_misaligned(op, a);
    berr = !mis && !(dly >= 0 && dly < TIMEOUT);
    if (mis) done_cyc = 1;
    else if (berr) done_cyc = TIMEOUT + 1;
    else done_cyc = dly + 2;
    exp = (mis || berr) ? 32'h0 : ref_load(op, a, w);
    @(posedge clk); #1;
    ld_req = 1'b1; ld_op = 3'(op); addr = a; mem_ack = 1'b0; mem_rdata = $urandom;
    #1;
    check("stall_c0", {31'b0, stall}, 32'd1);
    check("valid_c0", {31'b0, rd_valid}, 32'd0);
    for (int k = 1; k <= done_cyc; k++) begin
      @(posedge clk); #1;
      if (!mis && (k - 1) == dly) begin
        mem_ack = 1'b1; mem_rdata = w;
      end else begin
        mem_ack = 1'b0; mem_rdata = $urandom;
      end
      addr  = $urandom;
      ld_op = 3'($urandom);
      #1;
      if (k < done_cyc) begin
        check("wait_req", {31'b0, mem_req}, 32'd1);
        check("wait_stall", {31'b0, stall}, 32'd1);
        check("wait_valid", {31'b0, rd_valid}, 32'd0);
        check("wait_addr", mem_addr, a & ~32'h3);
      end else begin
        check("done_valid", {31'b0, rd_valid}, 32'd1);
        check("done_data", rd_data, exp);
        check("done_berr", {31'b0, bus_err}, {31'b0, berr});
        check("done_aexc", {31'b0, addr_exc}, {31'b0, mis});
        check("done_stall", {31'b0, stall}, 32'd0);
        check("done_req", {31'b0, mem_req}, 32'd0);
      end
    end
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
    ld_req = 1'b0; mem_ack = 1'b0;
    #1;
    check("idle_valid", {31'b0, rd_valid}, 32'd0);
    check("idle_stall", {31'b0, stall}, 32'd0);
    check("idle_req", {31'b0, mem_req}, 32'd0);
  endtask

  task automatic reset_during_wait();
    @(posedge clk); #1;
    ld_req = 1'b1; ld_op = 3'd0; addr = 32'h0000_0100; mem_ack = 1'b0;
    @(posedge clk); #2;
    check("rw_req", {31'b0, mem_req}, 32'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check("rw_stall_rst", {31'b0, stall}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0; ld_req = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
    #1;
    check("rw_req0", {31'b0, mem_req}, 32'd0);
    check("rw_addr0", mem_addr, 32'd0);
    check("rw_valid0", {31'b0, rd_valid}, 32'd0);
    check("rw_data0", rd_data, 32'd0);
    check("rw_flags0", {30'b0, bus_err, addr_exc}, 32'd0);
    @(posedge clk); #1;
    mem_ack = 1'b0;
    #1;
    check("rw_late_valid", {31'b0, rd_valid}, 32'd0);
    check("rw_late_req", {31'b0, mem_req}, 32'd0);
  endtask

  initial begin
    int op, dly, r;
    logic [31:0] a;
    reset = 1'b1; ld_req = 1'b1; ld_op = 3'd0; addr = 32'd0; mem_ack = 1'b0; mem_rdata = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_stall", {31'b0, stall}, 32'd0);
    check("rst_req", {31'b0, mem_req}, 32'd0);
    check("rst_addr", mem_addr, 32'd0);
    check("rst_data", rd_data, 32'd0);
    check("rst_flags", {29'b0, rd_valid, bus_err, addr_exc}, 32'd0);
    reset = 1'b0; ld_req = 1'b0;

    do_load(2, 32'h0000_1003, 32'h80FF_1234, 0);
    idle_cycle();
    do_load(3, 32'h0000_0002, 32'h9ABC_0001, 0);
    do_load(4, 32'h0000_0002, 32'h9ABC_0001, 0);
    do_load(0, 32'h0000_0000, 32'hDEAD_BEEF, 3);
    do_load(0, 32'h0000_0010, 32'h0, -1);
    idle_cycle();
    do_load(0, 32'h0000_0006, 32'hCAFE_F00D, 1);
    do_load(0, 32'h0000_0020, 32'h0BAD_CAFE, TIMEOUT - 1);
    do_load(1, 32'h0000_0021, 32'h0000_5500, TIMEOUT);
    reset_during_wait();
    do_load(1, 32'h0000_0042, 32'h00A5_0000, 1);
    idle_cycle();

    for (int i = 0; i < 150; i++) begin
      op = $urandom_range(0, 7);
      a  = $urandom;
      r  = $urandom_range(0, 9);
      if (r == 0) dly = -1;
      else if (r == 1) dly = TIMEOUT - 1 + $urandom_range(0, 1);
      else dly = $urandom_range(0, 4);
      do_load(op, a, $urandom, dly);
      if ($urandom_range(0, 2) == 0) idle_cycle();
    end
    idle_cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/load_extender.md
# load_extender

Load-return unit in the MEM stage of the pipelined CPU: the read-side counterpart of the immediate extender. It issues a word-aligned read to a handshaked data memory, waits for the acknowledge, selects the addressed byte or halfword, and zero- or sign-extends it to 32 bits for the MEM/WB register. While a load is outstanding it stalls the pipeline.

## Interface
Parameters:
- TIMEOUT, 16: maximum number of WAIT cycles without `mem_ack` before a bus error is reported. Legal range is 2..255.

Ports:
- clk  in  1  system clock; the block uses a single clock.
- reset  in  1  synchronous, active-high reset.
- ld_req  in  1  a load instruction is in the MEM stage.
- ld_op  in  3  load type: 000 LW, 001 LBU, 010 LB, 011 LHU, 100 LH. Codes 101–111 are treated as LW.
- addr  in  32  byte address of the load.
- mem_req  out  1  read request to the data memory, registered.
- mem_addr  out  32  word-aligned request address `{addr[31:2],2'b00}`, registered.
- mem_rdata  in  32  read data word, valid when `mem_ack` is high.
- mem_ack  in  1  read acknowledge, one cycle.
- rd_data  out  32  extended load result, registered.
- rd_valid  out  1  `rd_data` is valid; high for exactly one cycle.
- bus_err  out  1  the memory timed out; qualified by `rd_valid`.
- addr_exc  out  1  misaligned address; qualified by `rd_valid`. Only present in behaviour when `LOAD_EXT_EXC_EN` is defined.
- stall  out  1  combinational; freezes the PC and the IF/ID/EX/MEM registers.

## Operation
- States: IDLE, WAIT, DONE.
- IDLE:
  - `stall = ld_req`.
  - On `ld_req`, latch `ld_op`, `addr[1:0]` and `mem_addr`.
  - Misaligned address with exceptions enabled: go to DONE with `addr_exc=1` and `rd_data=0`; no memory request is issued.
  - Otherwise: go to WAIT with `mem_req=1` and the wait counter cleared.
- WAIT:
  - `stall=1`; `mem_req` and `mem_addr` are held stable.
  - On `mem_ack`: capture the extended data, `mem_req` goes to 0, go to DONE.
  - If the counter reaches TIMEOUT−1 with no ack: `bus_err=1`, `rd_data=0`, `mem_req` goes to 0, go to DONE.
  - Otherwise the counter increments.
- DONE:
  - `rd_valid=1`, `stall=0`, so the pipeline advances this cycle.
  - `ld_req` is ignored here, because it still refers to the finished load.
  - Unconditionally return to IDLE, clearing `rd_valid`, `bus_err` and `addr_exc`.
- Misalignment rules: LW requires `addr[1:0]==0`; LH and LHU require `addr[0]==0`; byte loads are never misaligned.
- Extraction is little-endian:
  - Byte: `mem_rdata[8b+7:8b]` with `b=addr[1:0]`.
  - Halfword: `mem_rdata[16h+15:16h]` with `h=addr[1]`.
- Extension:
  - LBU and LHU zero-extend.
  - LB replicates bit 7; LH replicates bit 15.
  - LW passes the word through unchanged.
- `mem_ack` in IDLE or DONE is ignored; the data is dropped.
- Reset values: state IDLE, and `mem_req`, `mem_addr`, `rd_data`, `rd_valid`, `bus_err`, `addr_exc` and the counter are all 0. `stall` is forced to 0 while `reset` is high.
- Reset during WAIT aborts the load: `mem_req` is 0 after the reset edge, and a late `mem_ack` is ignored.

## Timing
- Cycle 0: `ld_req` is seen in IDLE; `stall=1`.
- Cycle 1: WAIT with `mem_req=1`. If `mem_ack` is high in this cycle, cycle 2 is DONE.
- Minimum latency is 2 cycles from `ld_req` to `rd_valid`, with stall high for 2 cycles. Each extra ack-wait cycle adds 1.
- Timeout: `rd_valid` rises TIMEOUT+1 cycles after `ld_req`.
- Misaligned load (exceptions enabled): `rd_valid` one cycle after `ld_req`, stall high for 1 cycle.
- Back-to-back loads: a new `ld_req` is accepted in the cycle after DONE, so there is no lost cycle beyond the pipeline advance.
- `rd_data` and the flags hold only during the `rd_valid` cycle; the downstream MEM/WB register must capture them then.

## Configuration
- `LOAD_EXT_EXC_EN` defined: the alignment check is active, and `addr_exc` is reported as described above.
- `LOAD_EXT_EXC_EN` undefined:
  - `addr_exc` is tied to 0.
  - Misaligned loads are issued normally.
  - The low address bits are ignored and rounded down to the natural boundary: LW uses byte 0; LH and LHU use `addr[1]` only.

## Test plan
- LB at `addr=0x0000_1003`, `mem_rdata=0x80FF_1234`, ack on the first WAIT cycle → `rd_data=0xFFFF_FF80`, `rd_valid` on cycle 2, stall high on cycles 0–1, `mem_addr=0x0000_1000`.
- LHU at `addr=0x2`, `mem_rdata=0x9ABC_0001` → `rd_data=0x0000_9ABC`. LH with the same stimulus → `0xFFFF_9ABC`.
- LW with `mem_ack` delayed 3 cycles, `mem_rdata=0xDEAD_BEEF` → `mem_req` held 4 cycles, then `rd_data=0xDEAD_BEEF`, stall high for 5 cycles.
- LW with no ack, TIMEOUT=16 → `bus_err=1`, `rd_data=0`, `rd_valid` at cycle 17, `mem_req` low from then on.
- LW at `addr=0x6`:
  - With `LOAD_EXT_EXC_EN`: `addr_exc=1` on cycle 1, `mem_req` never asserted.
  - Without it: the request goes to `0x4` and returns the full word.
- `reset` pulsed during WAIT, followed by a late `mem_ack` → all outputs 0, state IDLE, no `rd_valid`. The next LBU completes correctly.
